// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, parity helper and
// the keyboard command bytes used by host software.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] ACK_BYTE    = 8'hFA;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pads, with a one-cycle
// falling-edge strobe on the synchronized clock.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fe
);

    logic clk_s1, clk_s2, clk_s3;
    logic data_s1, data_s2;

    // Idle PS/2 lines float high, so the flops reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= clk_in;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= data_in;
            data_s2 <= data_s1;
        end
    end

    assign clk_sync  = clk_s2;
    assign data_sync = data_s2;
    assign clk_fe    = clk_s3 & ~clk_s2;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then
// shifts start/data/parity/stop on device clock falling edges and checks the ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYCLES);

    ps2_tx_state_e    state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shreg;
    logic             parity_bit;
    logic             line_clk, line_data, line_fe;

    ps2_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .clk_in    (ps2_clk_in),
        .data_in   (ps2_data_in),
        .clk_sync  (line_clk),
        .data_sync (line_data),
        .clk_fe    (line_fe)
    );

    // Handshake: a byte transfers on any cycle where tx_valid && tx_ready are
    // both high; tx_data is captured on that edge. tx_valid while busy is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            parity_bit  <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shreg       <= tx_data;
                        parity_bit  <= odd_parity(tx_data);
                        cnt         <= '0;
                        bit_idx     <= '0;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        tx_ready    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    // Edges seen here are our own clock pull-down; ignore them.
                    if (cnt == INHIBIT_LAST) begin
                        cnt         <= '0;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        state       <= ST_REQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // Device-clocked phases share one inter-edge watchdog.
                    if (cnt == TIMEOUT_VAL) begin
                        cnt         <= '0;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_err      <= 1'b1;
                        tx_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= line_fe ? '0 : cnt + 1'b1;
                        case (state)
                            ST_REQ: begin
                                if (line_fe) begin
                                    ps2_data_oe <= ~shreg[0];
                                    shreg       <= {1'b0, shreg[7:1]};
                                    bit_idx     <= 4'd1;
                                    state       <= ST_SHIFT;
                                end
                            end
                            ST_SHIFT: begin
                                if (line_fe) begin
                                    bit_idx <= bit_idx + 1'b1;
                                    if (bit_idx < 4'd8) begin
                                        ps2_data_oe <= ~shreg[0];
                                        shreg       <= {1'b0, shreg[7:1]};
                                    end else if (bit_idx == 4'd8) begin
                                        ps2_data_oe <= ~parity_bit;
                                    end else begin
                                        ps2_data_oe <= 1'b0;
                                        state       <= ST_ACK;
                                    end
                                end
                            end
                            ST_ACK: begin
                                if (line_fe) begin
                                    if (!line_data) begin
                                        state <= ST_WAIT_IDLE;
                                    end else begin
                                        tx_err   <= 1'b1;
                                        tx_ready <= 1'b1;
                                        busy     <= 1'b0;
                                        state    <= ST_IDLE;
                                    end
                                end
                            end
                            ST_WAIT_IDLE: begin
                                if (line_clk && line_data) begin
                                    tx_done  <= 1'b1;
                                    tx_ready <= 1'b1;
                                    busy     <= 1'b0;
                                    state    <= ST_IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
